// File: rtl/tlp_pkg.sv
// Shared constants and state encoding for the completion TLP encoder.
// The byte-count helper is kept separate so the future multi-DW completer can reuse it.
package tlp_pkg;

   localparam logic [6:0] FMT_TYPE_CPL  = 7'h0A;
   localparam logic [6:0] FMT_TYPE_CPLD = 7'h4A;

   localparam logic [2:0] CPL_SC = 3'b000;
   localparam logic [2:0] CPL_UR = 3'b001;
   localparam logic [2:0] CPL_CA = 3'b100;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BEAT0 = 2'd1,
      ST_BEAT1 = 2'd2
   } state_e;

endpackage

// File: rtl/tlp_cpl_bytecount.sv
// Combinational byte count / lower address derivation for a completion,
// computed from the request's first byte enable, length and DW address.
module tlp_cpl_bytecount (
   input  logic [3:0]  i_first_be,
   input  logic [9:0]  i_length,
   input  logic [4:0]  i_addr_hi,
   output logic [11:0] o_byte_count,
   output logic [6:0]  o_lower_addr
);

   logic [1:0] w_lo;

   always_comb begin
      o_byte_count = 12'd1;
      if (i_length == 10'd1) begin
         casez (i_first_be)
            4'b1??1:                    o_byte_count = 12'd4;
            4'b01?1, 4'b1?10:           o_byte_count = 12'd3;
            4'b0011, 4'b0110, 4'b1100:  o_byte_count = 12'd2;
            default:                    o_byte_count = 12'd1;
         endcase
      end else begin
         // Length 0 encodes 1024 DW; the 12-bit truncation yields 0 as required.
         o_byte_count = {i_length, 2'b00};
      end
   end

   always_comb begin
      w_lo = 2'b00;
      casez (i_first_be)
         4'b???1, 4'b0000: w_lo = 2'b00;
         4'b??10:          w_lo = 2'b01;
         4'b?100:          w_lo = 2'b10;
         4'b1000:          w_lo = 2'b11;
         default:          w_lo = 2'b00;
      endcase
   end

   assign o_lower_addr = {i_addr_hi, w_lo};

endmodule

// File: rtl/tlp_cpl_encoder.sv
// Turns one decoder completion request into a 3DW Cpl/CplD on the 64-bit TX stream.
// Only one completion is in flight; tlp_enc_ready is high only while idle.
module tlp_cpl_encoder
   import tlp_pkg::*;
#(
   parameter int C_DATA_WIDTH = 64,
   parameter int STRB_WIDTH   = C_DATA_WIDTH / 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    lnk_up,
   input  logic                    tenc_req_compl,
   input  logic                    tenc_req_compl_wd,
   input  logic [2:0]              tenc_tc,
   input  logic [1:0]              tenc_attr,
   input  logic [9:0]              tenc_length,
   input  logic [15:0]             tenc_rid,
   input  logic [7:0]              tenc_tag,
   input  logic [7:0]              tenc_be,
   input  logic [12:0]             tenc_addr,
   input  logic [2:0]              tenc_compl_code,
   input  logic [31:0]             tenc_data,
   input  logic [15:0]             cfg_completer_id,
   output logic                    tlp_enc_ready,
   output logic [C_DATA_WIDTH-1:0] enc_tx_tdata,
   output logic [STRB_WIDTH-1:0]   enc_tx_tstrb,
   output logic                    enc_tx_tvalid,
   output logic                    enc_tx_tlast,
   input  logic                    enc_tx_tready,
   output logic [1:0]              o_dbg_state
);

   // TX handshake: a beat transfers on a rising edge where tvalid & tready;
   // while tready is low every TX output holds its value.

   state_e                  r_state;
   state_e                  w_state_nxt;
   logic                    r_ready;
   logic                    w_ready_nxt;
   logic [C_DATA_WIDTH-1:0] r_tdata;
   logic [C_DATA_WIDTH-1:0] w_tdata_nxt;
   logic [STRB_WIDTH-1:0]   r_tstrb;
   logic [STRB_WIDTH-1:0]   w_tstrb_nxt;
   logic                    r_tvalid;
   logic                    w_tvalid_nxt;
   logic                    r_tlast;
   logic                    w_tlast_nxt;

   logic                    r_is_wd;
   logic [15:0]             r_rid;
   logic [7:0]              r_tag;
   logic [6:0]              r_lower_addr;
   logic [31:0]             r_data;

   logic                    w_accept;
   logic                    w_is_wd;
   logic [11:0]             w_byte_count;
   logic [6:0]              w_lower_addr;
   logic [31:0]             w_dw0;
   logic [31:0]             w_dw1;
   logic [31:0]             w_dw2;
   logic [31:0]             w_dw3;
   logic                    w_unused;

   assign w_unused = ^{tenc_addr[12:7], tenc_addr[1:0], tenc_be[7:4]};

   tlp_cpl_bytecount u_bytecount (
      .i_first_be   (tenc_be[3:0]),
      .i_length     (tenc_length),
      .i_addr_hi    (tenc_addr[6:2]),
      .o_byte_count (w_byte_count),
      .o_lower_addr (w_lower_addr)
   );

   // compl_wd wins when both pulses arrive together.
   assign w_is_wd = tenc_req_compl_wd;

   assign w_dw0 = {1'b0, (w_is_wd ? FMT_TYPE_CPLD : FMT_TYPE_CPL), 1'b0, tenc_tc, 4'b0000,
                   1'b0, 1'b0, tenc_attr, 2'b00, (w_is_wd ? 10'd1 : 10'd0)};
   assign w_dw1 = {cfg_completer_id, tenc_compl_code, 1'b0, w_byte_count};
   assign w_dw2 = {r_rid, r_tag, 1'b0, r_lower_addr};
   assign w_dw3 = r_is_wd ? r_data : 32'h0000_0000;

   always_comb begin
      w_state_nxt  = r_state;
      w_ready_nxt  = r_ready;
      w_tdata_nxt  = r_tdata;
      w_tstrb_nxt  = r_tstrb;
      w_tvalid_nxt = r_tvalid;
      w_tlast_nxt  = r_tlast;
      w_accept     = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (lnk_up && (tenc_req_compl || tenc_req_compl_wd)) begin
               w_accept     = 1'b1;
               w_state_nxt  = ST_BEAT0;
               w_ready_nxt  = 1'b0;
               w_tdata_nxt  = {w_dw1, w_dw0};
               w_tstrb_nxt  = 8'hFF;
               w_tvalid_nxt = 1'b1;
               w_tlast_nxt  = 1'b0;
            end
         end
         ST_BEAT0: begin
            if (!lnk_up) begin
               w_state_nxt  = ST_IDLE;
               w_ready_nxt  = 1'b1;
               w_tdata_nxt  = '0;
               w_tstrb_nxt  = '0;
               w_tvalid_nxt = 1'b0;
               w_tlast_nxt  = 1'b0;
            end else if (enc_tx_tready) begin
               w_state_nxt  = ST_BEAT1;
               w_tdata_nxt  = {w_dw3, w_dw2};
               w_tstrb_nxt  = r_is_wd ? 8'hFF : 8'h0F;
               w_tlast_nxt  = 1'b1;
            end
         end
         ST_BEAT1: begin
            if (!lnk_up || enc_tx_tready) begin
               w_state_nxt  = ST_IDLE;
               w_ready_nxt  = 1'b1;
               w_tdata_nxt  = '0;
               w_tstrb_nxt  = '0;
               w_tvalid_nxt = 1'b0;
               w_tlast_nxt  = 1'b0;
            end
         end
         default: begin
            w_state_nxt  = ST_IDLE;
            w_ready_nxt  = 1'b1;
            w_tdata_nxt  = '0;
            w_tstrb_nxt  = '0;
            w_tvalid_nxt = 1'b0;
            w_tlast_nxt  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_ready  <= 1'b1;
         r_tdata  <= '0;
         r_tstrb  <= '0;
         r_tvalid <= 1'b0;
         r_tlast  <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_ready  <= w_ready_nxt;
         r_tdata  <= w_tdata_nxt;
         r_tstrb  <= w_tstrb_nxt;
         r_tvalid <= w_tvalid_nxt;
         r_tlast  <= w_tlast_nxt;
      end
   end

   // Second-beat fields are captured at acceptance so the decoder may move on.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_is_wd      <= 1'b0;
         r_rid        <= '0;
         r_tag        <= '0;
         r_lower_addr <= '0;
         r_data       <= '0;
      end else if (w_accept) begin
         r_is_wd      <= w_is_wd;
         r_rid        <= tenc_rid;
         r_tag        <= tenc_tag;
         r_lower_addr <= w_lower_addr;
         r_data       <= tenc_data;
      end
   end

   assign tlp_enc_ready = r_ready;
   assign enc_tx_tdata  = r_tdata;
   assign enc_tx_tstrb  = r_tstrb;
   assign enc_tx_tvalid = r_tvalid;
   assign enc_tx_tlast  = r_tlast;
   assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_tlp_cpl_encoder.sv
// Directed and randomized checks of the completion encoder against a
// byte-enable arithmetic model of the completion header.
module tb_tlp_cpl_encoder;
   import tlp_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        lnk_up = 1'b1;
   logic        tenc_req_compl = 1'b0;
   logic        tenc_req_compl_wd = 1'b0;
   logic [2:0]  tenc_tc = '0;
   logic [1:0]  tenc_attr = '0;
   logic [9:0]  tenc_length = '0;
   logic [15:0] tenc_rid = '0;
   logic [7:0]  tenc_tag = '0;
   logic [7:0]  tenc_be = '0;
   logic [12:0] tenc_addr = '0;
   logic [2:0]  tenc_compl_code = '0;
   logic [31:0] tenc_data = '0;
   logic [15:0] cfg_completer_id = '0;
   logic        tlp_enc_ready;
   logic [63:0] enc_tx_tdata;
   logic [7:0]  enc_tx_tstrb;
   logic        enc_tx_tvalid;
   logic        enc_tx_tlast;
   logic        enc_tx_tready = 1'b0;
   logic [1:0]  o_dbg_state;

   int n_checks = 0;
   int n_errors = 0;
   int hs_cnt = 0;

   tlp_cpl_encoder #(.C_DATA_WIDTH(64), .STRB_WIDTH(8)) dut (
      .clk               (clk),
      .reset             (reset),
      .lnk_up            (lnk_up),
      .tenc_req_compl    (tenc_req_compl),
      .tenc_req_compl_wd (tenc_req_compl_wd),
      .tenc_tc           (tenc_tc),
      .tenc_attr         (tenc_attr),
      .tenc_length       (tenc_length),
      .tenc_rid          (tenc_rid),
      .tenc_tag          (tenc_tag),
      .tenc_be           (tenc_be),
      .tenc_addr         (tenc_addr),
      .tenc_compl_code   (tenc_compl_code),
      .tenc_data         (tenc_data),
      .cfg_completer_id  (cfg_completer_id),
      .tlp_enc_ready     (tlp_enc_ready),
      .enc_tx_tdata      (enc_tx_tdata),
      .enc_tx_tstrb      (enc_tx_tstrb),
      .enc_tx_tvalid     (enc_tx_tvalid),
      .enc_tx_tlast      (enc_tx_tlast),
      .enc_tx_tready     (enc_tx_tready),
      .o_dbg_state       (o_dbg_state)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!reset && enc_tx_tvalid && enc_tx_tready) hs_cnt++;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_tvalid"}, 64'(enc_tx_tvalid), 64'd0);
      chk({tag, "_tlast"},  64'(enc_tx_tlast),  64'd0);
      chk({tag, "_ready"},  64'(tlp_enc_ready), 64'd1);
      chk({tag, "_state"},  64'(o_dbg_state),   64'(ST_IDLE));
   endtask

   task automatic check_beat(input string tag, input logic [63:0] d, input logic [7:0] s,
                             input logic l);
      chk({tag, "_tvalid"}, 64'(enc_tx_tvalid), 64'd1);
      chk({tag, "_tdata"},  enc_tx_tdata,       d);
      chk({tag, "_tstrb"},  64'(enc_tx_tstrb),  64'(s));
      chk({tag, "_tlast"},  64'(enc_tx_tlast),  64'(l));
      chk({tag, "_ready"},  64'(tlp_enc_ready), 64'd0);
   endtask

   // Reference model: header words from the field values currently driven.
   task automatic model(input bit wd, output logic [63:0] b0, output logic [63:0] b1,
                        output logic [7:0] s1);
      int lo = -1;
      int hi = -1;
      int bc;
      logic [1:0]  lo2;
      logic [31:0] dw0, dw1, dw2, dw3;
      for (int i = 0; i < 4; i++) begin
         if (tenc_be[i]) begin
            if (lo < 0) lo = i;
            hi = i;
         end
      end
      if (tenc_length == 10'd1) bc = (lo < 0) ? 1 : (hi - lo + 1);
      else bc = (int'(tenc_length) * 4) % 4096;
      lo2 = (lo < 0) ? 2'd0 : 2'(lo);
      dw0 = {1'b0, (wd ? 7'h4A : 7'h0A), 1'b0, tenc_tc, 4'b0, 2'b0, tenc_attr, 2'b0,
             (wd ? 10'd1 : 10'd0)};
      dw1 = {cfg_completer_id, tenc_compl_code, 1'b0, 12'(bc)};
      dw2 = {tenc_rid, tenc_tag, 1'b0, tenc_addr[6:2], lo2};
      dw3 = wd ? tenc_data : 32'h0;
      b0 = {dw1, dw0};
      b1 = {dw3, dw2};
      s1 = wd ? 8'hFF : 8'h0F;
   endtask

   task automatic drive_req(input bit c, input bit w);
      tenc_req_compl = c;
      tenc_req_compl_wd = w;
      @(negedge clk);
      tenc_req_compl = 1'b0;
      tenc_req_compl_wd = 1'b0;
   endtask

   task automatic expect_packet(input string tag, input logic [63:0] b0, input logic [63:0] b1,
                                input logic [7:0] s1, input int st0, input int st1);
      for (int i = 0; i <= st0; i++) begin
         check_beat({tag, "_b0"}, b0, 8'hFF, 1'b0);
         enc_tx_tready = (i == st0);
         @(negedge clk);
      end
      for (int i = 0; i <= st1; i++) begin
         check_beat({tag, "_b1"}, b1, s1, 1'b1);
         enc_tx_tready = (i == st1);
         @(negedge clk);
      end
      check_idle({tag, "_end"});
      enc_tx_tready = 1'b0;
   endtask

   task automatic set_base();
      tenc_tc = 3'd0; tenc_attr = 2'd0; tenc_length = 10'd1; tenc_rid = 16'h01a0;
      tenc_tag = 8'h09; tenc_be = 8'h0F; tenc_addr = 13'h0010; cfg_completer_id = 16'h0100;
      tenc_data = 32'hdeadbeef; tenc_compl_code = CPL_SC;
   endtask

   initial begin
      logic [63:0] b0, b1;
      logic [7:0]  s1;
      int          hs0;
      bit          wd;

      // Reset
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check_idle("reset");
      chk("reset_tdata", enc_tx_tdata, 64'd0);
      chk("reset_tstrb", 64'(enc_tx_tstrb), 64'd0);

      // 1: CplD happy path
      set_base();
      drive_req(0, 1);
      expect_packet("t1", 64'h01000004_4A000001, 64'hdeadbeef_01a00910, 8'hFF, 0, 0);

      // 2: UR Cpl
      tenc_compl_code = CPL_UR;
      drive_req(1, 0);
      expect_packet("t2", 64'h01002004_0A000000, 64'h00000000_01a00910, 8'h0F, 0, 0);

      // 3: byte count / lower address
      set_base();
      tenc_be = 8'h06; tenc_addr = 13'h0014;
      drive_req(0, 1);
      expect_packet("t3", 64'h01000002_4A000001, 64'hdeadbeef_01a00915, 8'hFF, 0, 0);

      // 4: backpressure
      set_base();
      model(1'b1, b0, b1, s1);
      hs0 = hs_cnt;
      drive_req(0, 1);
      expect_packet("t4", b0, b1, s1, 3, 2);
      chk("t4_handshakes", 64'(hs_cnt - hs0), 64'd2);

      // 5a: second request during BEAT0 ignored
      tenc_tag = 8'h3C; tenc_data = 32'h1234_5678;
      model(1'b1, b0, b1, s1);
      hs0 = hs_cnt;
      drive_req(0, 1);
      tenc_tag = 8'h77; tenc_data = 32'hffff_0000; tenc_req_compl = 1'b1;
      @(negedge clk);
      tenc_req_compl = 1'b0; tenc_tag = 8'h3C; tenc_data = 32'h1234_5678;
      expect_packet("t5a", b0, b1, s1, 0, 0);
      repeat (3) @(negedge clk);
      check_idle("t5a_quiet");
      chk("t5a_handshakes", 64'(hs_cnt - hs0), 64'd2);

      // 5b: both pulses give CplD
      model(1'b1, b0, b1, s1);
      drive_req(1, 1);
      expect_packet("t5b", b0, b1, s1, 1, 0);

      // 5c: link down ignores requests
      lnk_up = 1'b0;
      drive_req(0, 1);
      check_idle("t5c_a");
      @(negedge clk);
      check_idle("t5c_b");
      lnk_up = 1'b1;
      @(negedge clk);

      // 6a: reset in BEAT1
      drive_req(0, 1);
      enc_tx_tready = 1'b1;
      @(negedge clk);
      chk("t6a_in_beat1", 64'(enc_tx_tlast), 64'd1);
      enc_tx_tready = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check_idle("t6a");
      chk("t6a_tdata", enc_tx_tdata, 64'd0);
      chk("t6a_tstrb", 64'(enc_tx_tstrb), 64'd0);

      // 6b: link drop in BEAT0
      drive_req(1, 0);
      lnk_up = 1'b0;
      @(negedge clk);
      check_idle("t6b");
      lnk_up = 1'b1;
      @(negedge clk);

      // Randomized packets
      for (int n = 0; n < 40; n++) begin
         tenc_tc = 3'($urandom); tenc_attr = 2'($urandom);
         tenc_length = ($urandom_range(0, 2) == 0) ? 10'($urandom) : 10'd1;
         tenc_rid = 16'($urandom); tenc_tag = 8'($urandom); tenc_be = 8'($urandom);
         tenc_addr = 13'($urandom); tenc_data = $urandom; cfg_completer_id = 16'($urandom);
         case ($urandom_range(0, 2))
            0: tenc_compl_code = CPL_SC;
            1: tenc_compl_code = CPL_UR;
            default: tenc_compl_code = CPL_CA;
         endcase
         wd = 1'($urandom);
         model(wd, b0, b1, s1);
         drive_req(!wd, wd);
         expect_packet("rnd", b0, b1, s1, $urandom_range(0, 3), $urandom_range(0, 3));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
